sha256_msg_padder: RTL and testbench

//  Upstream stage of simplified_sha256. Reads a raw MSG_WORDS-word message from memory at src_addr and

---
 rtl/sha256_msg_padder.sv | 131 +++++++++++++
 tb/tb_sha256_msg_padder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: copies a MSG_WORDS-word message to dst_addr and appends the 0x8000_0000
// marker, zero fill and 64-bit bit length. Define PADDER_BSWAP_EN to byte-reverse message words.
module sha256_msg_padder #(
  parameter int MSG_WORDS = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] src_addr,
  input  logic [15:0] dst_addr,
  output logic        done,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam int          BLOCKS       = (MSG_WORDS + 2) / 16 + 1;
  localparam int          TOTAL_WORDS  = 16 * BLOCKS;
  localparam logic [15:0] LAST_MSG_IDX = 16'(MSG_WORDS - 1);
  localparam logic [15:0] PAD_IDX      = 16'(MSG_WORDS);
  localparam logic [15:0] LAST_IDX     = 16'(TOTAL_WORDS - 1);
  localparam logic [31:0] BIT_LEN      = 32'(MSG_WORDS * 32);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_MSG,
    WR_PAD,
    DONE
  } state_t;

  state_t      state_q;
  logic        done_q;
  logic        we_q;
  logic [15:0] addr_q;
  logic [31:0] wdata_q;
  logic [15:0] idx_q;
  logic [15:0] src_q;
  logic [15:0] dst_q;
  logic [31:0] msg_word_d;
  logic [31:0] pad_word_d;

  assign mem_clk        = clk;
  assign done           = done_q;
  assign mem_we         = we_q;
  assign mem_addr       = addr_q;
  assign mem_write_data = wdata_q;

  always_comb begin
`ifdef PADDER_BSWAP_EN
    msg_word_d = {mem_read_data[7:0], mem_read_data[15:8],
                  mem_read_data[23:16], mem_read_data[31:24]};
`else
    msg_word_d = mem_read_data;
`endif
  end

  // The length-high word falls into the zero-fill default.
  always_comb begin
    pad_word_d = 32'h0000_0000;
    if (idx_q == PAD_IDX) begin
      pad_word_d = 32'h8000_0000;
    end else if (idx_q == LAST_IDX) begin
      pad_word_d = BIT_LEN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 32'h0000_0000;
      idx_q   <= 16'h0000;
      src_q   <= 16'h0000;
      dst_q   <= 16'h0000;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          we_q   <= 1'b0;
          if (start) begin
            src_q   <= src_addr;
            dst_q   <= dst_addr;
            idx_q   <= 16'h0000;
            addr_q  <= src_addr;
            state_q <= RD_WAIT;
          end
        end
        RD_REQ: begin
          we_q    <= 1'b0;
          addr_q  <= src_q + idx_q;
          state_q <= RD_WAIT;
        end
        RD_WAIT: begin
          we_q    <= 1'b0;
          state_q <= WR_MSG;
        end
        WR_MSG: begin
          wdata_q <= msg_word_d;
          addr_q  <= dst_q + idx_q;
          we_q    <= 1'b1;
          idx_q   <= idx_q + 16'h0001;
          state_q <= (idx_q == LAST_MSG_IDX) ? WR_PAD : RD_REQ;
        end
        WR_PAD: begin
          wdata_q <= pad_word_d;
          addr_q  <= dst_q + idx_q;
          we_q    <= 1'b1;
          idx_q   <= idx_q + 16'h0001;
          if (idx_q == LAST_IDX) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          we_q    <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Scoreboard bench for sha256_msg_padder: three instances (20, 13, 14 words) share stimulus, each with
// its own memory model, expected-write queue and expected-done queue.
module tb_sha256_msg_padder;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  localparam int NWA [3] = '{20, 13, 14};
  localparam int TOT [3] = '{32, 16, 32};
  localparam int LAT [3] = '{72, 42, 60};

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;
  int          cyc;
  int          total;
  int          bad;

  wr_t exp_q  [3][$];
  int  done_q [3][$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Untouched memory holds 0x1000_0000+addr; one special word exercises byte order.
  function automatic logic [31:0] src_word(input logic [15:0] a);
    return (a == 16'h0300) ? 32'h0102_0304 : (32'h1000_0000 | {16'h0000, a});
  endfunction

  function automatic logic [31:0] exp_msg(input logic [15:0] a);
    logic [31:0] w;
    w = src_word(a);
`ifdef PADDER_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  function automatic void push_run(input int k, input logic [15:0] src, input logic [15:0] dst,
                                   input int lim, input int s, input bit with_done);
    wr_t w;
    for (int i = 0; i < TOT[k] && i < lim; i++) begin
      w.addr = dst + 16'(i);
      if (i < NWA[k])          w.data = exp_msg(src + 16'(i));
      else if (i == NWA[k])    w.data = 32'h8000_0000;
      else if (i == TOT[k] - 1) w.data = 32'(NWA[k] * 32);
      else                     w.data = 32'h0000_0000;
      exp_q[k].push_back(w);
    end
    if (with_done) done_q[k].push_back(s + LAT[k]);
  endfunction

  function automatic int pending();
    int p;
    p = 0;
    for (int k = 0; k < 3; k++) p += exp_q[k].size() + done_q[k].size();
    return p;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_inst
      localparam int N = (gi == 0) ? 20 : ((gi == 1) ? 13 : 14);
      logic        done;
      logic        mem_clk;
      logic        mem_we;
      logic [15:0] mem_addr;
      logic [31:0] mem_wdata;
      logic [31:0] mem_rdata;
      logic [31:0] mem     [0:65535];
      bit          written [0:65535];
      wr_t         exp_w;

      sha256_msg_padder #(.MSG_WORDS(N)) u_dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .src_addr       (src_addr),
        .dst_addr       (dst_addr),
        .done           (done),
        .mem_clk        (mem_clk),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_wdata),
        .mem_read_data  (mem_rdata)
      );

      always @(posedge mem_clk) begin
        if (mem_we) begin
          mem[mem_addr]     <= mem_wdata;
          written[mem_addr] <= 1'b1;
        end
        mem_rdata <= written[mem_addr] ? mem[mem_addr] : src_word(mem_addr);
      end

      always @(negedge clk) begin
        if (!reset) begin
          if (mem_we) begin
            if (exp_q[gi].size() == 0) begin
              chk("wr_unexpected", 32'(mem_we), 32'h0);
            end else begin
              exp_w = exp_q[gi].pop_front();
              chk("wr_addr", 32'(mem_addr), 32'(exp_w.addr));
              chk("wr_data", mem_wdata, exp_w.data);
            end
          end
          if (done) begin
            if (done_q[gi].size() == 0) begin
              chk("done_unexpected", 32'(done), 32'h0);
            end else begin
              chk("done_cycle", 32'(cyc), 32'(done_q[gi].pop_front()));
              $display("inst %0d (MSG_WORDS=%0d) done at cyc %0d", gi, N, cyc);
            end
          end
        end
      end
    end
  endgenerate

  task automatic pulse_start(input logic [15:0] src, input logic [15:0] dst, output int s);
    src_addr = src;
    dst_addr = dst;
    start    = 1'b1;
    s        = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (pending() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(pending()), 32'h0);
    repeat (5) @(negedge clk);
  endtask

  task automatic full_run(input logic [15:0] src, input logic [15:0] dst);
    int s;
    pulse_start(src, dst, s);
    for (int k = 0; k < 3; k++) push_run(k, src, dst, 64, s, 1'b1);
    wait_idle(300);
  endtask

  initial begin
    int s;
    total    = 0;
    bad      = 0;
    reset    = 1'b1;
    start    = 1'b0;
    src_addr = 16'h0000;
    dst_addr = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_done", 32'(g_inst[0].done), 32'h0);
    chk("rst_we", 32'(g_inst[0].mem_we), 32'h0);
    chk("rst_addr", 32'(g_inst[0].mem_addr), 32'h0);
    chk("rst_wdata", g_inst[0].mem_wdata, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // T1 / T2: full runs for 20, 13 and 14 words
    full_run(16'h0000, 16'h0100);
    chk("t1_pad", g_inst[0].mem[16'h0114], 32'h8000_0000);
    chk("t1_lenhi", g_inst[0].mem[16'h011E], 32'h0000_0000);
    chk("t1_len", g_inst[0].mem[16'h011F], 32'h0000_0280);
    chk("t2_13_pad", g_inst[1].mem[16'h010D], 32'h8000_0000);
    chk("t2_13_len", g_inst[1].mem[16'h010F], 32'h0000_01A0);
    chk("t2_14_len", g_inst[2].mem[16'h011F], 32'h0000_01C0);

    // T3: reset in the 10th cycle of a run; only the first three writes may appear
    pulse_start(16'h0000, 16'h0100, s);
    for (int k = 0; k < 3; k++) push_run(k, 16'h0000, 16'h0100, 3, s, 1'b0);
    wait_cyc(s + 9);
    reset = 1'b1;
    #1;
    chk("t3_addr", 32'(g_inst[0].mem_addr), 32'h0);
    chk("t3_wdata", g_inst[0].mem_wdata, 32'h0);
    chk("t3_we", 32'(g_inst[0].mem_we), 32'h0);
    chk("t3_done", 32'(g_inst[0].done), 32'h0);
    chk("t3_addr14", 32'(g_inst[2].mem_addr), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("t3_partial", 32'(pending()), 32'h0);
    repeat (3) @(negedge clk);
    full_run(16'h0000, 16'h0100);

    // T4 (+ byte order word): mid-run pulse ignored, then start held through done
    pulse_start(16'h0300, 16'h0400, s);
    for (int k = 0; k < 3; k++) begin
      push_run(k, 16'h0300, 16'h0400, 64, s, 1'b1);
      push_run(k, 16'h0300, 16'h0400, 64, s + LAT[k] + 1, 1'b1);
    end
    wait_cyc(s + 9);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cyc(s + 29);
    start = 1'b1;
    wait_cyc(s + 73);
    chk("t4_restart_addr", 32'(g_inst[0].mem_addr), 32'h0000_0300);
    start = 1'b0;
    wait_idle(400);
`ifdef PADDER_BSWAP_EN
    chk("t6_swap", g_inst[0].mem[16'h0400], 32'h0403_0201);
`else
    chk("t6_noswap", g_inst[0].mem[16'h0400], 32'h0102_0304);
`endif
    chk("t6_pad", g_inst[0].mem[16'h0414], 32'h8000_0000);

    // T5: address wrap on both source and destination
    full_run(16'hFFF8, 16'hFFF0);
`ifdef PADDER_BSWAP_EN
    chk("t5_first", g_inst[0].mem[16'hFFF0], 32'hF8FF_0010);
    chk("t5_last_msg", g_inst[0].mem[16'h0003], 32'h0B00_0010);
`else
    chk("t5_first", g_inst[0].mem[16'hFFF0], 32'h1000_FFF8);
    chk("t5_last_msg", g_inst[0].mem[16'h0003], 32'h1000_000B);
`endif
    chk("t5_pad", g_inst[0].mem[16'h0004], 32'h8000_0000);
    chk("t5_len", g_inst[0].mem[16'h000F], 32'h0000_0280);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
